// File: rtl/sram_dp_cfg.sv
// rtl/sram_dp_cfg.sv - parametrised true dual-port synchronous SRAM with clear sequencer
//
// Ports:
//   iClk              clock shared by both ports
//   iRst              synchronous reset, active-high
//   iCEnA / iCEnB     chip enable, active-low
//   iWEnA / iWEnB     write enable, active-low (1 = read)
//   iBWEnA / iBWEnB   per-bit write enable, active-low
//   iAddrA / iAddrB   word address
//   iWDataA / iWDataB write data
//   oRDataA / oRDataB read data, held until the next read on that port
//   oCollision        both ports enabled on the same address, aligned with read data
//   oReady            accesses are accepted
module sram_dp_cfg #(
    parameter int DW         = 16,
    parameter int AW         = 14,
    parameter int RD_LAT     = 1,
    parameter int RDW_NEW    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iCEnA,
    input  logic          iCEnB,
    input  logic          iWEnA,
    input  logic          iWEnB,
    input  logic [DW-1:0] iBWEnA,
    input  logic [DW-1:0] iBWEnB,
    input  logic [AW-1:0] iAddrA,
    input  logic [AW-1:0] iAddrB,
    input  logic [DW-1:0] iWDataA,
    input  logic [DW-1:0] iWDataB,
    output logic [DW-1:0] oRDataA,
    output logic [DW-1:0] oRDataB,
    output logic          oCollision,
    output logic          oReady
);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, CLEAR, READY} seqState_t;

    seqState_t state, stateNext;
    logic [AW:0] clrCnt;
    logic        clrLast;

    logic [DW-1:0] mem [DEPTH];

    // The counter steps by two, so the last clear cycle is the one whose
    // pair reaches the top of the array.
    assign clrLast = (clrCnt + (AW+1)'(2)) >= (AW+1)'(DEPTH);
    assign oReady  = (state == READY);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state  <= IDLE;
            clrCnt <= '0;
        end else begin
            state  <= stateNext;
            clrCnt <= (state == CLEAR) ? clrCnt + (AW+1)'(2) : '0;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = (INIT_CLEAR != 0) ? CLEAR : READY;
            CLEAR:   if (clrLast) stateNext = READY;
            READY:   stateNext = READY;
            default: stateNext = IDLE;
        endcase
    end

    logic          accA, accB, wrA, wrB, rdA, rdB, sameAddr;
    logic [DW-1:0] oldA, oldB, mergedB, newA, rdDataA, rdDataB;

    assign accA     = ~iCEnA & oReady & ~iRst;
    assign accB     = ~iCEnB & oReady & ~iRst;
    assign wrA      = accA & ~iWEnA;
    assign wrB      = accB & ~iWEnB;
    assign rdA      = accA & iWEnA;
    assign rdB      = accB & iWEnB;
    assign sameAddr = accA & accB & (iAddrA == iAddrB);

    assign oldA    = mem[iAddrA];
    assign oldB    = mem[iAddrB];
    assign mergedB = (oldB & iBWEnB) | (iWDataB & ~iBWEnB);
    // On a same-address dual write, A's word is built on top of B's merge so
    // that A wins only on the bits it actually enables.
    assign newA    = (((sameAddr & wrB) ? mergedB : oldA) & iBWEnA) | (iWDataA & ~iBWEnA);

    assign rdDataA = ((RDW_NEW != 0) && sameAddr && wrB) ? mergedB : oldA;
    assign rdDataB = ((RDW_NEW != 0) && sameAddr && wrA) ? newA    : oldB;

    always_ff @(posedge iClk) begin
        if (state == CLEAR) begin
            mem[clrCnt[AW-1:0]] <= '0;
            if (DEPTH > 1) mem[clrCnt[AW-1:0] + AW'(1)] <= '0;
        end else begin
            if (wrA) mem[iAddrA] <= newA;
            // A's write already carries B's bits when both hit one word.
            if (wrB && !(sameAddr && wrA)) mem[iAddrB] <= mergedB;
        end
    end

    logic [DW-1:0] rdA1, rdB1;
    logic          vA1, vB1, col1;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            rdA1       <= '0;
            rdB1       <= '0;
            vA1        <= 1'b0;
            vB1        <= 1'b0;
            col1       <= 1'b0;
            oRDataA    <= '0;
            oRDataB    <= '0;
            oCollision <= 1'b0;
        end else begin
            rdA1 <= rdDataA;
            rdB1 <= rdDataB;
            vA1  <= rdA;
            vB1  <= rdB;
            col1 <= sameAddr;
            if (RD_LAT == 2) begin
                if (vA1) oRDataA <= rdA1;
                if (vB1) oRDataB <= rdB1;
                oCollision <= col1;
            end else begin
                if (rdA) oRDataA <= rdDataA;
                if (rdB) oRDataB <= rdDataB;
                oCollision <= sameAddr;
            end
        end
    end
endmodule

// File: tb/tb_sram_dp_cfg.sv
// tb/tb_sram_dp_cfg.sv - randomized model-checked bench for sram_dp_cfg
module tb_sram_dp_cfg;
    localparam int DW        = 16;
    localparam int AW        = 4;
    localparam int DEPTH     = 16;
    localparam int CLR_EDGES = 1 + DEPTH / 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, ceA, ceB, weA, weB;
    logic [DW-1:0] bweA, bweB, wdA, wdB;
    logic [AW-1:0] adA, adB;
    logic [DW-1:0] r1A, r1B, r2A, r2B, r3A, r3B;
    logic          c1, c2, c3, rdy1, rdy2, rdy3;

    sram_dp_cfg #(.DW(DW), .AW(AW), .RD_LAT(1), .RDW_NEW(0), .INIT_CLEAR(1)) u1 (
        .iClk(clk), .iRst(rst), .iCEnA(ceA), .iCEnB(ceB), .iWEnA(weA), .iWEnB(weB),
        .iBWEnA(bweA), .iBWEnB(bweB), .iAddrA(adA), .iAddrB(adB),
        .iWDataA(wdA), .iWDataB(wdB), .oRDataA(r1A), .oRDataB(r1B),
        .oCollision(c1), .oReady(rdy1));

    sram_dp_cfg #(.DW(DW), .AW(AW), .RD_LAT(2), .RDW_NEW(1), .INIT_CLEAR(1)) u2 (
        .iClk(clk), .iRst(rst), .iCEnA(ceA), .iCEnB(ceB), .iWEnA(weA), .iWEnB(weB),
        .iBWEnA(bweA), .iBWEnB(bweB), .iAddrA(adA), .iAddrB(adB),
        .iWDataA(wdA), .iWDataB(wdB), .oRDataA(r2A), .oRDataB(r2B),
        .oCollision(c2), .oReady(rdy2));

    sram_dp_cfg #(.DW(DW), .AW(AW), .RD_LAT(1), .RDW_NEW(0), .INIT_CLEAR(0)) u3 (
        .iClk(clk), .iRst(rst), .iCEnA(ceA), .iCEnB(ceB), .iWEnA(weA), .iWEnB(weB),
        .iBWEnA(bweA), .iBWEnB(bweB), .iAddrA(adA), .iAddrB(adB),
        .iWDataA(wdA), .iWDataB(wdB), .oRDataA(r3A), .oRDataB(r3B),
        .oCollision(c3), .oReady(rdy3));

    int errors, checks;

    // Reference: word array plus "edges since reset released".
    logic [DW-1:0] mdl [DEPTH];
    int            relCnt;
    logic [DW-1:0] e1A, e1B, e2A, e2B, pdA, pdB;
    logic          ec1, ec2, pvA, pvB, pcol;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        ceA = 1'b1; ceB = 1'b1; weA = 1'b1; weB = 1'b1;
        bweA = '1; bweB = '1; wdA = '0; wdB = '0; adA = '0; adB = '0;
    endtask

    task automatic randInputs();
        ceA  = ($urandom_range(0, 3) == 0);
        ceB  = ($urandom_range(0, 3) == 0);
        weA  = 1'($urandom_range(0, 1));
        weB  = 1'($urandom_range(0, 1));
        bweA = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom());
        bweB = ($urandom_range(0, 2) == 0) ? '0 : DW'($urandom());
        wdA  = DW'($urandom());
        wdB  = DW'($urandom());
        adA  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
        adB  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom());
    endtask

    // Advance one clock with the currently driven inputs, update the model
    // and compare every DUT output just after the edge.
    task automatic step();
        logic [DW-1:0] newMem [DEPTH];
        logic          rdyNow, accA, accB, same, vA, vB;
        logic [DW-1:0] oldRdA, oldRdB, newRdA, newRdB;
        rdyNow = (relCnt >= CLR_EDGES);
        accA   = !rst && rdyNow && !ceA;
        accB   = !rst && rdyNow && !ceB;
        same   = accA && accB && (adA == adB);
        newMem = mdl;
        if (accA && !weA)
            for (int i = 0; i < DW; i++)
                if (!bweA[i]) newMem[adA][i] = wdA[i];
        if (accB && !weB)
            for (int i = 0; i < DW; i++)
                if (!bweB[i] && !(same && !weA && !bweA[i])) newMem[adB][i] = wdB[i];
        vA     = accA && weA;
        vB     = accB && weB;
        oldRdA = mdl[adA];
        oldRdB = mdl[adB];
        newRdA = newMem[adA];
        newRdB = newMem[adB];
        @(posedge clk);
        mdl = newMem;
        if (rst) begin
            relCnt = 0;
            e1A = '0; e1B = '0; e2A = '0; e2B = '0; ec1 = 1'b0; ec2 = 1'b0;
            pvA = 1'b0; pvB = 1'b0; pcol = 1'b0; pdA = '0; pdB = '0;
        end else begin
            relCnt++;
            if (relCnt == CLR_EDGES)
                for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
            if (vA) e1A = oldRdA;
            if (vB) e1B = oldRdB;
            ec1 = same;
            if (pvA) e2A = pdA;
            if (pvB) e2B = pdB;
            ec2 = pcol;
            pvA = vA; pdA = newRdA;
            pvB = vB; pdB = newRdB;
            pcol = same;
        end
        #1;
        checkVal("rdy1", 32'(rdy1), 32'(relCnt >= CLR_EDGES));
        checkVal("rdy2", 32'(rdy2), 32'(relCnt >= CLR_EDGES));
        checkVal("rdy3", 32'(rdy3), 32'(relCnt >= 1));
        checkVal("d1A", 32'(r1A), 32'(e1A));
        checkVal("d1B", 32'(r1B), 32'(e1B));
        checkVal("col1", 32'(c1), 32'(ec1));
        checkVal("d2A", 32'(r2A), 32'(e2A));
        checkVal("d2B", 32'(r2B), 32'(e2B));
        checkVal("col2", 32'(c2), 32'(ec2));
    endtask

    initial begin
        errors = 0; checks = 0; relCnt = 0;
        e1A = '0; e1B = '0; e2A = '0; e2B = '0; ec1 = 1'b0; ec2 = 1'b0;
        pvA = 1'b0; pvB = 1'b0; pcol = 1'b0; pdA = '0; pdB = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        idle();
        rst = 1'b1;
        repeat (3) step();

        // Clear with ignored traffic; reset again at clear cycle 3.
        rst = 1'b0;
        repeat (4) begin randInputs(); step(); end
        rst = 1'b1; idle();
        repeat (2) step();
        rst = 1'b0;
        repeat (CLR_EDGES - 1) begin randInputs(); step(); end
        idle();
        step();
        checkVal("ready_after_clear", 32'(rdy1), 32'd1);

        for (int i = 0; i < DEPTH; i++) begin
            idle(); ceA = 1'b0; adA = AW'(i);
            step();
            checkVal("clear_rd", 32'(r1A), 32'h0);
        end
        idle(); step(); step();

        // Write A, read B: latency 1 vs 2.
        ceA = 1'b0; weA = 1'b0; adA = 4'hF; wdA = 16'h1234; bweA = '0;
        step();
        idle(); ceB = 1'b0; adB = 4'hF;
        step();
        checkVal("wr_rd_lat1", 32'(r1B), 32'h1234);
        checkVal("wr_rd_lat2_early", 32'(r2B), 32'h0);
        idle(); step();
        checkVal("wr_rd_lat2", 32'(r2B), 32'h1234);

        // Masked write.
        ceA = 1'b0; weA = 1'b0; adA = 4'h1; wdA = 16'hFFFF; bweA = '0;
        step();
        wdA = 16'h0000; bweA = 16'hFF00;
        step();
        idle(); ceA = 1'b0; adA = 4'h1;
        step();
        checkVal("masked", 32'(r1A), 32'hFF00);

        // Same-address dual write.
        idle();
        ceA = 1'b0; weA = 1'b0; adA = 4'h2; wdA = 16'hDEAD; bweA = 16'h00FF;
        ceB = 1'b0; weB = 1'b0; adB = 4'h2; wdB = 16'hBEEF; bweB = 16'h0000;
        step();
        checkVal("dual_col", 32'(c1), 32'd1);
        idle(); ceA = 1'b0; adA = 4'h2;
        step();
        checkVal("dual_col_once", 32'(c1), 32'd0);
        checkVal("dual_data", 32'(r1A), 32'hDEEF);

        // Cross-port read-during-write.
        idle(); ceA = 1'b0; weA = 1'b0; adA = 4'h3; wdA = 16'h1111; bweA = '0;
        step();
        wdA = 16'hBEEF; ceB = 1'b0; adB = 4'h3;
        step();
        checkVal("rdw_old", 32'(r1B), 32'h1111);
        idle(); step();
        checkVal("rdw_new", 32'(r2B), 32'hBEEF);

        repeat (400) begin randInputs(); step(); end

        // Reset with reads in flight, then full clear and more traffic.
        randInputs(); ceA = 1'b0; weA = 1'b1; ceB = 1'b0; weB = 1'b1;
        step();
        rst = 1'b1; randInputs();
        step();
        rst = 1'b0;
        repeat (CLR_EDGES + 200) begin randInputs(); step(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
